// File: rtl/word_round_ctrl.sv
// word_round_ctrl: round sequencer for the typing game.
// Latches a target word, presents one target character at a time, checks
// each accepted keystroke, keeps a revealed-character buffer ('-' for hidden
// positions), counts strikes (wrong keys and per-character timeouts) and ends
// the round in WIN or LOSE. Every output comes straight from a register.
module word_round_ctrl #(
   parameter int WORD_LEN       = 4,
   parameter int MAX_WRONG      = 3,
   parameter int TIMEOUT_CYCLES = 100000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7*WORD_LEN-1:0] target_word,
   input  logic                  key_valid,
   input  logic [6:0]            key_ascii,
   output logic [6:0]            selection,
   output logic [2:0]            pos,
   output logic [7*WORD_LEN-1:0] revealed,
   output logic [3:0]            wrong_cnt,
   output logic                  busy,
   output logic                  win,
   output logic                  lose,
   output logic                  done
);

   localparam int              WB         = 7 * WORD_LEN;
   localparam int              TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]      POS_LAST   = 3'(WORD_LEN - 1);
   localparam logic [3:0]      WRONG_MAX  = 4'(MAX_WRONG);
   localparam logic [6:0]      DASH       = 7'h2D;
   localparam logic [WB-1:0]   DASH_WORD  = {WORD_LEN{DASH}};

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_KEY = 3'd1,
      ST_CHECK    = 3'd2,
      ST_WIN      = 3'd3,
      ST_LOSE     = 3'd4
   } state_t;

   // Pick character idx out of a packed word (char 0 in the low bits).
   function automatic logic [6:0] char_at(input logic [WB-1:0] word, input logic [2:0] idx);
      logic [6:0] ch;
      ch = 7'h00;
      for (int i = 0; i < WORD_LEN; i++) begin
         if (idx == 3'(i)) begin
            ch = word[7*i +: 7];
         end else begin
            ch = ch;
         end
      end
      return ch;
   endfunction

   // Return word with character idx replaced by ch.
   function automatic logic [WB-1:0] set_char(input logic [WB-1:0] word, input logic [2:0] idx,
                                              input logic [6:0] ch);
      logic [WB-1:0] w;
      w = word;
      for (int i = 0; i < WORD_LEN; i++) begin
         if (idx == 3'(i)) begin
            w[7*i +: 7] = ch;
         end else begin
            w[7*i +: 7] = word[7*i +: 7];
         end
      end
      return w;
   endfunction

   // Registered state
   state_t          state_r;
   logic [WB-1:0]   word_r;
   logic [6:0]      key_r;
   logic [TW-1:0]   timer_r;
   logic [2:0]      pos_r;
   logic [3:0]      wrong_r;
   logic [WB-1:0]   revealed_r;
   logic [6:0]      selection_r;
   logic            busy_r;
   logic            win_r;
   logic            lose_r;
   logic            done_r;

   // Next-state values
   state_t          state_s;
   logic [WB-1:0]   word_s;
   logic [6:0]      key_s;
   logic [TW-1:0]   timer_s;
   logic [2:0]      pos_s;
   logic [3:0]      wrong_s;
   logic [WB-1:0]   revealed_s;
   logic [6:0]      selection_s;
   logic            busy_s;
   logic            win_s;
   logic            lose_s;
   logic            done_s;
   logic            strike_s;
   logic [3:0]      wrong_inc_s;

   // Next-state logic: round sequencing, key checking, strikes and timeouts.
   always_comb begin
      state_s     = state_r;
      word_s      = word_r;
      key_s       = key_r;
      timer_s     = timer_r;
      pos_s       = pos_r;
      wrong_s     = wrong_r;
      revealed_s  = revealed_r;
      strike_s    = 1'b0;
      // Saturating increment so the strike counter can never wrap.
      if (wrong_r < WRONG_MAX) begin
         wrong_inc_s = wrong_r + 4'd1;
      end else begin
         wrong_inc_s = WRONG_MAX;
      end

      case (state_r)
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (start) begin
               word_s     = target_word;
               revealed_s = DASH_WORD;
               pos_s      = 3'd0;
               wrong_s    = 4'd0;
               timer_s    = '0;
               state_s    = ST_WAIT_KEY;
            end else begin
               state_s    = state_r;
            end
         end
         ST_WAIT_KEY: begin
            // A key in the timeout cycle wins over the timeout.
            if (key_valid) begin
               key_s   = key_ascii;
               timer_s = '0;
               state_s = ST_CHECK;
            end else if (timer_r == TIMER_LAST) begin
               timer_s  = '0;
               strike_s = 1'b1;
            end else begin
               timer_s  = timer_r + TW'(1);
            end
         end
         ST_CHECK: begin
            if (key_r == char_at(word_r, pos_r)) begin
               revealed_s = set_char(revealed_r, pos_r, key_r);
               if (pos_r == POS_LAST) begin
                  state_s = ST_WIN;
               end else begin
                  pos_s   = pos_r + 3'd1;
                  state_s = ST_WAIT_KEY;
               end
            end else begin
               strike_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Common strike handling for mismatches and timeouts.
      if (strike_s) begin
         wrong_s = wrong_inc_s;
         if (wrong_inc_s == WRONG_MAX) begin
            revealed_s = word_r;
            state_s    = ST_LOSE;
         end else begin
            state_s    = ST_WAIT_KEY;
         end
      end else begin
         wrong_s = wrong_s;
      end

      busy_s      = (state_s == ST_WAIT_KEY) || (state_s == ST_CHECK);
      selection_s = busy_s ? char_at(word_s, pos_s) : DASH;
      win_s       = (state_s == ST_WIN);
      lose_s      = (state_s == ST_LOSE);
      done_s      = (win_s && (state_r != ST_WIN)) || (lose_s && (state_r != ST_LOSE));
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         word_r      <= '0;
         key_r       <= 7'h00;
         timer_r     <= '0;
         pos_r       <= 3'd0;
         wrong_r     <= 4'd0;
         revealed_r  <= DASH_WORD;
         selection_r <= DASH;
         busy_r      <= 1'b0;
         win_r       <= 1'b0;
         lose_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         word_r      <= word_s;
         key_r       <= key_s;
         timer_r     <= timer_s;
         pos_r       <= pos_s;
         wrong_r     <= wrong_s;
         revealed_r  <= revealed_s;
         selection_r <= selection_s;
         busy_r      <= busy_s;
         win_r       <= win_s;
         lose_r      <= lose_s;
         done_r      <= done_s;
      end
   end

   assign selection = selection_r;
   assign pos       = pos_r;
   assign revealed  = revealed_r;
   assign wrong_cnt = wrong_r;
   assign busy      = busy_r;
   assign win       = win_r;
   assign lose      = lose_r;
   assign done      = done_r;

endmodule

// File: tb/tb_word_round_ctrl.sv
// Directed self-checking bench for word_round_ctrl (WORD_LEN=4, MAX_WRONG=3,
// TIMEOUT_CYCLES=8). Outputs are sampled 1 time unit after each rising edge.
module tb_word_round_ctrl;

   localparam logic [27:0] DASH4 = {7'h2D, 7'h2D, 7'h2D, 7'h2D};
   localparam logic [27:0] CAFE  = {7'h45, 7'h46, 7'h41, 7'h43};
   localparam logic [27:0] R1    = {7'h2D, 7'h2D, 7'h2D, 7'h43};
   localparam logic [27:0] R2    = {7'h2D, 7'h2D, 7'h41, 7'h43};
   localparam logic [27:0] R3    = {7'h2D, 7'h46, 7'h41, 7'h43};

   logic        clk;
   logic        rst;
   logic        start;
   logic [27:0] target_word;
   logic        key_valid;
   logic [6:0]  key_ascii;
   logic [6:0]  selection;
   logic [2:0]  pos;
   logic [27:0] revealed;
   logic [3:0]  wrong_cnt;
   logic        busy;
   logic        win;
   logic        lose;
   logic        done;

   int checks = 0;
   int errors = 0;

   word_round_ctrl #(
      .WORD_LEN(4),
      .MAX_WRONG(3),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .target_word(target_word),
      .key_valid(key_valid),
      .key_ascii(key_ascii),
      .selection(selection),
      .pos(pos),
      .revealed(revealed),
      .wrong_cnt(wrong_cnt),
      .busy(busy),
      .win(win),
      .lose(lose),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Key strobe for one cycle, then one more cycle so the CHECK result is visible.
   task automatic press(input logic [6:0] ch);
      key_ascii = ch;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      tick();
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      target_word = 28'h0;
      key_valid = 1'b0;
      key_ascii = 7'h00;

      // Reset / idle
      tick();
      tick();
      rst = 1'b0;
      check("rst_revealed", 64'(revealed), 64'(DASH4));
      check("rst_selection", 64'(selection), 64'(7'h2D));
      check("rst_busy", 64'(busy), 64'(1'b0));
      check("rst_win", 64'(win), 64'(1'b0));
      check("rst_lose", 64'(lose), 64'(1'b0));
      check("rst_done", 64'(done), 64'(1'b0));
      check("rst_pos", 64'(pos), 64'(3'd0));
      check("rst_wrong", 64'(wrong_cnt), 64'(4'd0));
      press(7'h43);
      check("idle_key_busy", 64'(busy), 64'(1'b0));
      check("idle_key_revealed", 64'(revealed), 64'(DASH4));

      // Clean win on "CAFE"
      target_word = CAFE;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", 64'(busy), 64'(1'b1));
      check("start_selection", 64'(selection), 64'(7'h43));
      check("start_pos", 64'(pos), 64'(3'd0));
      press(7'h43);
      check("win_c_pos", 64'(pos), 64'(3'd1));
      check("win_c_revealed", 64'(revealed), 64'(R1));
      check("win_c_selection", 64'(selection), 64'(7'h41));
      tick();
      press(7'h41);
      check("win_a_pos", 64'(pos), 64'(3'd2));
      check("win_a_revealed", 64'(revealed), 64'(R2));
      tick();
      press(7'h46);
      check("win_f_pos", 64'(pos), 64'(3'd3));
      check("win_f_revealed", 64'(revealed), 64'(R3));
      tick();
      press(7'h45);
      check("win_flag", 64'(win), 64'(1'b1));
      check("win_done", 64'(done), 64'(1'b1));
      check("win_busy", 64'(busy), 64'(1'b0));
      check("win_revealed", 64'(revealed), 64'(CAFE));
      check("win_wrong", 64'(wrong_cnt), 64'(4'd0));
      check("win_selection", 64'(selection), 64'(7'h2D));
      tick();
      check("win_done_drop", 64'(done), 64'(1'b0));
      check("win_hold", 64'(win), 64'(1'b1));

      // New round from WIN, then mismatch followed by a correct key
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_win", 64'(win), 64'(1'b0));
      check("restart_wrong", 64'(wrong_cnt), 64'(4'd0));
      check("restart_revealed", 64'(revealed), 64'(DASH4));
      check("restart_pos", 64'(pos), 64'(3'd0));
      press(7'h58);
      check("mis_wrong", 64'(wrong_cnt), 64'(4'd1));
      check("mis_pos", 64'(pos), 64'(3'd0));
      check("mis_revealed", 64'(revealed), 64'(DASH4));
      press(7'h43);
      check("fix_revealed", 64'(revealed), 64'(R1));
      check("fix_pos", 64'(pos), 64'(3'd1));

      // start while busy is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_start_pos", 64'(pos), 64'(3'd1));
      check("busy_start_revealed", 64'(revealed), 64'(R1));

      // Lose: lowercase 'a' is not 'A' (no case folding), then 'Z'
      press(7'h61);
      check("case_wrong", 64'(wrong_cnt), 64'(4'd2));
      check("case_pos", 64'(pos), 64'(3'd1));
      press(7'h5A);
      check("lose_flag", 64'(lose), 64'(1'b1));
      check("lose_done", 64'(done), 64'(1'b1));
      check("lose_revealed", 64'(revealed), 64'(CAFE));
      check("lose_wrong", 64'(wrong_cnt), 64'(4'd3));
      check("lose_busy", 64'(busy), 64'(1'b0));
      tick();
      check("lose_done_drop", 64'(done), 64'(1'b0));
      press(7'h58);
      check("lose_key_ignored", 64'(wrong_cnt), 64'(4'd3));
      check("lose_hold", 64'(lose), 64'(1'b1));

      // Timeout: strike 8 cycles after WAIT_KEY entry
      start = 1'b1;
      tick();
      start = 1'b0;
      check("to_start_lose", 64'(lose), 64'(1'b0));
      repeat (7) tick();
      check("to_before", 64'(wrong_cnt), 64'(4'd0));
      tick();
      check("to_strike", 64'(wrong_cnt), 64'(4'd1));
      check("to_busy", 64'(busy), 64'(1'b1));
      check("to_pos", 64'(pos), 64'(3'd0));
      // Key arrives on the timeout cycle: it wins, no strike
      repeat (7) tick();
      key_ascii = 7'h43;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check("to_key_nostrike", 64'(wrong_cnt), 64'(4'd1));
      tick();
      check("to_key_pos", 64'(pos), 64'(3'd1));
      check("to_key_revealed", 64'(revealed), 64'(R1));
      check("to_key_wrong", 64'(wrong_cnt), 64'(4'd1));

      // Back-to-back strobes: the second (wrong) one is dropped
      key_ascii = 7'h41;
      key_valid = 1'b1;
      tick();
      key_ascii = 7'h51;
      tick();
      key_valid = 1'b0;
      tick();
      check("b2b_pos", 64'(pos), 64'(3'd2));
      check("b2b_wrong", 64'(wrong_cnt), 64'(4'd1));
      check("b2b_revealed", 64'(revealed), 64'(R2));

      // Reset while in CHECK
      key_ascii = 7'h46;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstchk_busy", 64'(busy), 64'(1'b0));
      check("rstchk_pos", 64'(pos), 64'(3'd0));
      check("rstchk_revealed", 64'(revealed), 64'(DASH4));
      check("rstchk_wrong", 64'(wrong_cnt), 64'(4'd0));
      check("rstchk_selection", 64'(selection), 64'(7'h2D));
      check("rstchk_done", 64'(done), 64'(1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/word_round_ctrl.md
# word_round_ctrl

Round sequencer for the Lab 4 typing game. It latches a target word, presents one target character at a time as the active selection, and checks each registered keystroke against it. It keeps a revealed-character buffer for the display ('-' for unrevealed positions), counts wrong attempts and per-character timeouts, and ends the round in WIN or LOSE. It sits between the keyboard/ASCII decode front end and the seven-segment/VGA display logic.

## Interface
- WORD_LEN, 4: characters per word (2..8).
- MAX_WRONG, 3: wrong attempts (including timeouts) that end the round (1..15).
- TIMEOUT_CYCLES, 100000000: WAIT_KEY cycles before a timeout strike (≥2).

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a round from IDLE, WIN or LOSE.
- target_word  in  7*WORD_LEN  ASCII word; char i at bits [7i+6:7i], char 0 typed first; sampled only on accepted start.
- key_valid  in  1  one-cycle strobe; key_ascii valid.
- key_ascii  in  7  typed ASCII code.
- selection  out  7  target char at current position; 0x2D when not in WAIT_KEY/CHECK.
- pos  out  3  current position index.
- revealed  out  7*WORD_LEN  display buffer, same packing as target_word.
- wrong_cnt  out  4  strikes so far.
- busy  out  1  high in WAIT_KEY or CHECK.
- win  out  1  high while in WIN.
- lose  out  1  high while in LOSE.
- done  out  1  one-cycle pulse on entry to WIN or LOSE.

## Operation
- States: IDLE, WAIT_KEY, CHECK, WIN, LOSE. All outputs registered.
- Reset: state=IDLE, pos=0, wrong_cnt=0, revealed all 0x2D, selection=0x2D, busy=win=lose=done=0, timer=0, word and key registers cleared.
- IDLE/WIN/LOSE + start: latch target_word, revealed all 0x2D, pos=0, wrong_cnt=0, timer=0 → WAIT_KEY. Without start, hold all outputs.
- WAIT_KEY: timer increments every cycle.
  - key_valid: latch key_ascii, timer=0 → CHECK. key_valid takes priority over a timeout in the same cycle.
  - Timer reaches TIMEOUT_CYCLES-1 with no key_valid: timer=0 and record a strike (same rule as a mismatch below); stay in WAIT_KEY or go to LOSE.
- CHECK (one cycle):
  - key == selection: revealed[pos] = key.
    - If pos == WORD_LEN-1 → WIN.
    - Otherwise pos+1 → WAIT_KEY.
  - key != selection: strike.
- Strike: wrong_cnt+1.
  - If the new value equals MAX_WRONG → LOSE, and revealed loads the full latched word.
  - Otherwise → WAIT_KEY with pos unchanged.
- key_valid outside WAIT_KEY is ignored, including during CHECK.
- start in WAIT_KEY/CHECK is ignored.
- Comparison is exact on 7 bits; no case folding.
- wrong_cnt saturates at MAX_WRONG and never wraps.

## Timing
- key_valid in cycle N → CHECK in N+1 → revealed/pos/wrong_cnt/state updated and visible at N+2.
- Minimum spacing between accepted keys: 2 cycles. A strobe at N+1 is dropped.
- start in cycle N → busy=1 and selection=char 0 at N+1.
- done is high exactly one cycle, coincident with the first cycle win or lose is high.
- Timeout strike: the first key-free WAIT_KEY cycle counts as timer=0; the strike takes effect TIMEOUT_CYCLES cycles after WAIT_KEY entry (or after the previous key/strike).
- rst has priority over every event in the same cycle, including mid-CHECK.

## Test plan
- Reset/idle: assert rst 2 cycles → revealed=all 0x2D, selection=0x2D, busy=win=lose=done=0; key_valid in IDLE ignored.
- Clean win, target "CAFE" (0x43,0x41,0x46,0x45): start, then keys C,A,F,E spaced 3 cycles → pos steps 0..3, revealed fills progressively, win=1, done pulses once, wrong_cnt=0.
- Mismatch then correct: key 'X' at pos 0 → wrong_cnt=1, pos=0, revealed unchanged; then 'C' → revealed char0=0x43, pos=1.
- Lose by strikes (MAX_WRONG=3): three wrong keys → lose=1, done pulses, revealed="CAFE", wrong_cnt=3; a fourth key is ignored.
- Timeout (TIMEOUT_CYCLES=8): no key for 8 cycles → wrong_cnt=1. Then key_valid on the timeout cycle → no strike; key goes to CHECK.
- Back-to-back and reset: key strobes at N and N+1 → only the first is checked. rst asserted in CHECK → IDLE reset values next cycle. start from WIN → new round with wrong_cnt=0.
